ttl_counter_sequencer: RTL and testbench
========================================

# ttl_counter_sequencer

- Control stage directly upstream of a 74x461-style presettable counter.
- Drives the counter's mode code (m1/m0), carry-in (CI_n) and parallel-load data (D).
- Consumes its ripple-carry output (CO_n) to run it as a programmable one-shot or periodic divider of N qualified ticks.
- Emits a terminal-count strobe per expiry; an optional sticky interrupt flag is compiled in by macro.

## Interface
- WIDTH, 8, counter width; must match the driven counter.
- clk  input  1  rising-edge clock, shared with the counter.
- RST_n  input  1  asynchronous, active-low reset.
- start  input  1  (re)start: latch period and oneshot, load counter.
- stop  input  1  abort: clear counter, return to IDLE.
- oneshot  input  1  1 = single expiry, 0 = periodic; sampled with start.
- tick_en  input  1  qualifies a tick; counter advances only when high.
- period  input  WIDTH  N, ticks per expiry, 1..2^WIDTH-1; 0 is illegal.
- CO_n  input  1  counter ripple carry; low when counter = all ones.
- m1, m0  output  1 each  counter mode: 00 clear, 01 hold, 10 load, 11 count.
- CI_n  output  1  counter carry-in, active low.
- D  output  WIDTH  preset to counter, 2^WIDTH − N mod 2^WIDTH.
- busy  output  1  high in RUN.
- tc  output  1  terminal-tick strobe.
- irq  output  1  sticky expiry flag (TTL_SEQ_IRQ_EN only; else tied 0).
- irq_ack  input  1  clears irq (TTL_SEQ_IRQ_EN only; else ignored).

## Operation
- States: IDLE, RUN. Registers: state, period_r, oneshot_r, irq.
- m1, m0, CI_n and tc are combinational (Mealy) from state, RST_n, start, stop, tick_en and CO_n.
  - No register sits between CO_n and the mode outputs.
- D = 0 − period (WIDTH-bit wrap).
  - In IDLE, or when start is high, period is taken from the input.
  - Otherwise period is taken from period_r.
- Priority, evaluated each cycle: reset > stop > start > terminal tick > tick > hold.
- While RST_n low: m1m0 = 00, CI_n = 1, so the counter clears on every edge during reset.
- IDLE:
  - start with period ≠ 0: m1m0 = 10; latch period_r and oneshot_r; → RUN.
  - start with period = 0: ignored; m1m0 = 01; stay IDLE.
  - Otherwise: m1m0 = 01, CI_n = 1.
- RUN:
  - stop: m1m0 = 00; → IDLE.
  - start: restart exactly as from IDLE; period = 0 → m1m0 = 00, → IDLE.
  - Terminal tick (tick_en & !CO_n): tc = 1.
    - If oneshot_r: m1m0 = 00, → IDLE.
    - Otherwise: m1m0 = 10 (reload D).
  - Tick (tick_en & CO_n): m1m0 = 11, CI_n = 0.
  - No tick: m1m0 = 11, CI_n = 1 (count mode, no increment).
- Arithmetic:
  - After load, the counter holds 2^W − N and reaches all ones after N−1 ticks; the Nth tick is terminal. Expiry period is exactly N ticks.
  - N = 1: preset = all ones, so every qualified tick is terminal.
- stop and start are level-sampled each cycle. The source must pulse them for one cycle.

## Timing
- Reset values: state IDLE, period_r 0, oneshot_r 0, irq 0, busy 0, tc 0, m1m0 00, CI_n 1. D = 0 − period (combinational).
- Load latency: start in cycle k → counter = preset after edge k; busy high from cycle k+1.
- tc is high in the same cycle as the terminal tick. The reload or clear takes effect at the closing edge.
- With tick_en held high and N periodic, tc pulses every N cycles.
- CO_n must settle within the cycle. The combinational path runs CO_n → m1/m0 → counter.

## Configuration
- TTL_SEQ_IRQ_EN defined:
  - irq sets on the edge closing any cycle with tc = 1.
  - irq clears on irq_ack.
  - Set wins over a simultaneous ack.
  - irq is reset by RST_n.
- Undefined: no irq register; irq = 0; irq_ack unused.

## Test plan
- Reset asserted mid-RUN → next cycle m1m0 = 00, busy = 0, counter model = 0; after release m1m0 = 01.
- WIDTH = 8, period = 5, periodic, tick_en = 1 → D = 0xFB; tc every 5 cycles; counter sequence FB, FC, FD, FE, FF, FB.
- period = 3, oneshot, tick_en toggling 1/0 → tc once on the 3rd qualified tick; then IDLE, counter 0, busy 0.
- period = 1 periodic → tc on every tick_en cycle; counter stays FF; m1m0 = 10 each tick.
- Restart: start with period = 7 in RUN at count FD → D = 0xF9 loaded; stop and start in the same cycle → m1m0 = 00, IDLE; start with period = 0 in IDLE → ignored.
- TTL_SEQ_IRQ_EN: tc and irq_ack in the same cycle → irq = 1; later lone irq_ack → irq = 0.

Source files
------------

// File: rtl/ttl_counter_sequencer.sv
// rtl/ttl_counter_sequencer.sv - one-shot/periodic divide-by-N sequencer driving a 74x461-style counter
// Optional sticky expiry interrupt compiled in with TTL_SEQ_IRQ_EN.
module ttl_counter_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             RST_n,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
    input  logic             tick_en,
    input  logic [WIDTH-1:0] period,
    input  logic             CO_n,
    input  logic             irq_ack,
    output logic             m1,
    output logic             m0,
    output logic             CI_n,
    output logic [WIDTH-1:0] D,
    output logic             busy,
    output logic             tc,
    output logic             irq
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_CLEAR = 2'b00;
    localparam logic [1:0] MODE_HOLD  = 2'b01;
    localparam logic [1:0] MODE_LOAD  = 2'b10;
    localparam logic [1:0] MODE_COUNT = 2'b11;

    state_t           state;
    logic [WIDTH-1:0] period_r;
    logic             oneshot_r;

    logic [1:0]       mode;
    logic             ci_n_c;
    logic             tc_c;
    logic             load_req;
    logic             go_idle;
    logic [WIDTH-1:0] preset_src;

    // Mealy decode: CO_n reaches the mode pins with no register in between,
    // so the reload/clear lands on the same edge as the terminal tick.
    always_comb begin
        mode     = MODE_HOLD;
        ci_n_c   = 1'b1;
        tc_c     = 1'b0;
        load_req = 1'b0;
        go_idle  = 1'b0;
        if (!RST_n) begin
            mode = MODE_CLEAR;
        end else if (stop) begin
            mode    = MODE_CLEAR;
            go_idle = 1'b1;
        end else if (start) begin
            if (period != '0) begin
                mode     = MODE_LOAD;
                load_req = 1'b1;
            end else if (state == RUN) begin
                mode    = MODE_CLEAR;
                go_idle = 1'b1;
            end
        end else if (state == RUN) begin
            if (tick_en && !CO_n) begin
                tc_c = 1'b1;
                if (oneshot_r) begin
                    mode    = MODE_CLEAR;
                    go_idle = 1'b1;
                end else begin
                    mode = MODE_LOAD;
                end
            end else begin
                mode   = MODE_COUNT;
                ci_n_c = !tick_en;
            end
        end
    end

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state     <= IDLE;
            period_r  <= '0;
            oneshot_r <= 1'b0;
        end else if (load_req) begin
            state     <= RUN;
            period_r  <= period;
            oneshot_r <= oneshot;
        end else if (go_idle) begin
            state <= IDLE;
        end
    end

    // Preset is the two's complement of N so the counter hits all ones after N-1 ticks.
    assign preset_src = ((state == IDLE) || start) ? period : period_r;
    assign D          = '0 - preset_src;

    assign m1   = mode[1];
    assign m0   = mode[0];
    assign CI_n = ci_n_c;
    assign tc   = tc_c;
    assign busy = (state == RUN);

`ifdef TTL_SEQ_IRQ_EN
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            irq <= 1'b0;
        end else if (tc_c) begin
            irq <= 1'b1;
        end else if (irq_ack) begin
            irq <= 1'b0;
        end
    end
`else
    logic unused_irq_ack;
    assign unused_irq_ack = irq_ack;
    assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_ttl_counter_sequencer.sv
// tb/tb_ttl_counter_sequencer.sv - bench for ttl_counter_sequencer with a behavioural 74x461 counter
module tb_ttl_counter_sequencer;
    localparam int W = 8;
`ifdef TTL_SEQ_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         RST_n = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         oneshot = 1'b0;
    logic         tick_en = 1'b0;
    logic         irq_ack = 1'b0;
    logic [W-1:0] period = 8'd9;
    logic         CO_n, m1, m0, CI_n, busy, tc, irq;
    logic [W-1:0] D;
    logic [W-1:0] cnt;

    int tests = 0;
    int failures = 0;

    // Reference: a run is "ticks remaining until expiry"; the counter value follows from it.
    bit m_run = 0, m_one = 0, m_irq = 0;
    int m_left = 0, m_n = 0;
    logic [21:0] exp_vec;
    logic [21:0] obs_vec;

    ttl_counter_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .RST_n(RST_n), .start(start), .stop(stop), .oneshot(oneshot),
        .tick_en(tick_en), .period(period), .CO_n(CO_n), .irq_ack(irq_ack),
        .m1(m1), .m0(m0), .CI_n(CI_n), .D(D), .busy(busy), .tc(tc), .irq(irq)
    );

    always #5 clk = ~clk;

    assign CO_n    = ~&cnt;
    assign obs_vec = {m1, m0, CI_n, tc, busy, irq, D, cnt};

    always @(posedge clk) begin
        case ({m1, m0})
            2'b00:   cnt <= '0;
            2'b10:   cnt <= D;
            2'b11:   if (!CI_n) cnt <= cnt + 8'd1;
            default: cnt <= cnt;
        endcase
    end

    task automatic cycle(input bit st, input bit sp, input bit os, input bit te,
                         input logic [W-1:0] p, input bit ack);
        logic [1:0] em;
        bit eci, etc;
        logic [W-1:0] ed;
        @(negedge clk);
        start = st; stop = sp; oneshot = os; tick_en = te; period = p; irq_ack = ack;
        #1;
        em  = 2'b01;
        eci = 1'b1;
        etc = 1'b0;
        ed  = (!m_run || st) ? 8'(256 - int'(p)) : 8'(256 - m_n);
        exp_vec = {2'b00, 1'b0, 1'b0, m_run, IRQ_ON && m_irq, ed,
                   m_run ? 8'(256 - m_left) : 8'h00};
        if (sp) begin
            em = 2'b00; m_run = 0;
        end else if (st) begin
            if (p != 0) begin
                em = 2'b10; m_run = 1; m_n = int'(p); m_left = int'(p); m_one = os;
            end else if (m_run) begin
                em = 2'b00; m_run = 0;
            end
        end else if (m_run) begin
            if (te && m_left == 1) begin
                etc = 1'b1;
                if (m_one) begin
                    em = 2'b00; m_run = 0;
                end else begin
                    em = 2'b10; m_left = m_n;
                end
            end else begin
                em = 2'b11;
                eci = !te;
                if (te) m_left = m_left - 1;
            end
        end
        exp_vec[21:18] = {em, eci, etc};
        if (etc) m_irq = 1;
        else if (ack) m_irq = 0;
    endtask

    task automatic test_reset;
        @(negedge clk); #1;
        tests++;
        if ({m1, m0, CI_n, tc, busy, irq} !== 6'b001000 || cnt !== 8'h00 || D !== 8'hF7) begin
            failures++;
            $display("FAIL reset_state: got %b cnt=%h D=%h want 001000 cnt=00 D=f7",
                     {m1, m0, CI_n, tc, busy, irq}, cnt, D);
        end
        RST_n = 1'b1;
        cycle(1, 0, 0, 1, 8'd20, 0);
        repeat (4) cycle(0, 0, 0, 1, 8'd0, 0);
        tests++;
        if (obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL reset_prerun: got %h want %h", obs_vec, exp_vec);
        end
        @(negedge clk);
        RST_n = 1'b0;
        #1;
        tests++;
        if ({m1, m0, CI_n, tc, busy, irq} !== 6'b001000) begin
            failures++;
            $display("FAIL reset_midrun_outputs: got %b want 001000", {m1, m0, CI_n, tc, busy, irq});
        end
        @(negedge clk); #1;
        tests++;
        if (cnt !== 8'h00 || {m1, m0} !== 2'b00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_midrun_counter: got cnt=%h mode=%b busy=%b want 00/00/0", cnt, {m1, m0}, busy);
        end
        RST_n = 1'b1;
        m_run = 0; m_irq = 0;
        cycle(0, 0, 0, 0, 8'd0, 0);
        tests++;
        if (obs_vec !== exp_vec || {m1, m0} !== 2'b01) begin
            failures++;
            $display("FAIL reset_release: got %h want %h (mode 01)", obs_vec, exp_vec);
        end
    endtask

    task automatic test_periodic;
        int ntc, last, n;
        cycle(1, 0, 0, 1, 8'd5, 0);
        tests++;
        if (D !== 8'hFB || obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL periodic_load: got D=%h vec=%h want D=fb vec=%h", D, obs_vec, exp_vec);
        end
        ntc = 0; last = -1;
        for (int i = 0; i < 25; i++) begin
            cycle(0, 0, 0, 1, 8'd0, 0);
            tests++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL periodic5 cyc %0d: got %h want %h", i, obs_vec, exp_vec);
            end
            if (tc === 1'b1) begin
                tests++;
                if (last >= 0 && i - last != 5) begin
                    failures++;
                    $display("FAIL periodic5_spacing: got %0d want 5", i - last);
                end
                last = i; ntc++;
            end
        end
        tests++;
        if (ntc != 5) begin
            failures++;
            $display("FAIL periodic5_count: got %0d want 5", ntc);
        end
        n = $urandom_range(2, 12);
        cycle(1, 0, 0, 1, 8'(n), 0);
        ntc = 0;
        for (int i = 0; i < 3 * n; i++) begin
            cycle(0, 0, 0, 1, 8'(n), 0);
            tests++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL periodic_n%0d cyc %0d: got %h want %h", n, i, obs_vec, exp_vec);
            end
            if (tc === 1'b1) ntc++;
        end
        tests++;
        if (ntc != 3) begin
            failures++;
            $display("FAIL periodic_n%0d_count: got %0d want 3", n, ntc);
        end
        cycle(0, 1, 0, 0, 8'd0, 0);
    endtask

    task automatic test_oneshot;
        int ntc = 0;
        cycle(1, 0, 1, 0, 8'd3, 0);
        for (int i = 0; i < 12; i++) begin
            cycle(0, 0, 0, (i % 2) == 0, 8'd0, 0);
            tests++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL oneshot3 cyc %0d: got %h want %h", i, obs_vec, exp_vec);
            end
            if (tc === 1'b1) ntc++;
        end
        tests++;
        if (ntc != 1 || busy !== 1'b0 || cnt !== 8'h00) begin
            failures++;
            $display("FAIL oneshot3_end: got tc=%0d busy=%b cnt=%h want 1/0/00", ntc, busy, cnt);
        end
    endtask

    task automatic test_period_one;
        bit te;
        cycle(1, 0, 0, 0, 8'd1, 0);
        for (int i = 0; i < 12; i++) begin
            te = 1'($urandom_range(0, 1));
            cycle(0, 0, 0, te, 8'd0, 0);
            tests++;
            if (obs_vec !== exp_vec || cnt !== 8'hFF || (te && ({m1, m0} !== 2'b10 || tc !== 1'b1))) begin
                failures++;
                $display("FAIL period1 cyc %0d te=%0d: got %h want %h", i, te, obs_vec, exp_vec);
            end
        end
        cycle(0, 1, 0, 0, 8'd0, 0);
    endtask

    task automatic test_restart;
        cycle(1, 0, 0, 1, 8'd5, 0);
        cycle(0, 0, 0, 1, 8'd0, 0);
        cycle(0, 0, 0, 1, 8'd0, 0);
        cycle(1, 0, 0, 1, 8'd7, 0);
        tests++;
        if (obs_vec !== exp_vec || cnt !== 8'hFD || D !== 8'hF9 || {m1, m0} !== 2'b10) begin
            failures++;
            $display("FAIL restart_load: got %h want %h (cnt fd D f9)", obs_vec, exp_vec);
        end
        cycle(0, 0, 0, 0, 8'd0, 0);
        tests++;
        if (obs_vec !== exp_vec || cnt !== 8'hF9) begin
            failures++;
            $display("FAIL restart_preset: got %h want %h", obs_vec, exp_vec);
        end
        cycle(1, 1, 0, 1, 8'd7, 0);
        tests++;
        if (obs_vec !== exp_vec || {m1, m0} !== 2'b00) begin
            failures++;
            $display("FAIL stop_start: got %h want %h", obs_vec, exp_vec);
        end
        cycle(1, 0, 0, 1, 8'd0, 0);
        tests++;
        if (obs_vec !== exp_vec || {m1, m0} !== 2'b01 || busy !== 1'b0) begin
            failures++;
            $display("FAIL start_zero_idle: got %h want %h", obs_vec, exp_vec);
        end
        cycle(0, 0, 0, 1, 8'd0, 0);
        tests++;
        if (obs_vec !== exp_vec || busy !== 1'b0) begin
            failures++;
            $display("FAIL start_zero_after: got %h want %h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_irq;
        cycle(1, 0, 0, 1, 8'd2, 0);
        cycle(0, 0, 0, 1, 8'd0, 1);
        cycle(0, 0, 0, 1, 8'd0, 1);
        tests++;
        if (obs_vec !== exp_vec || tc !== 1'b1) begin
            failures++;
            $display("FAIL irq_tc_with_ack: got %h want %h", obs_vec, exp_vec);
        end
        cycle(0, 0, 0, 0, 8'd0, 0);
        tests++;
        if (obs_vec !== exp_vec || irq !== IRQ_ON) begin
            failures++;
            $display("FAIL irq_set_wins: got irq=%b want %b", irq, IRQ_ON);
        end
        cycle(0, 0, 0, 0, 8'd0, 1);
        cycle(0, 0, 0, 0, 8'd0, 0);
        tests++;
        if (obs_vec !== exp_vec || irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_ack_clear: got irq=%b want 0", irq);
        end
        cycle(0, 1, 0, 0, 8'd0, 0);
    endtask

    task automatic test_random;
        logic [W-1:0] p;
        for (int i = 0; i < 400; i++) begin
            p = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 4)) : 8'($urandom);
            cycle($urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), p, $urandom_range(0, 7) == 0);
            tests++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL random cyc %0d: got %h want %h", i, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_period_one();
        test_restart();
        test_irq();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
